alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 12-bit combinational ALU: fetches operands from an
// 8x12 register file, sequences one instruction at a time, writes back and reports.
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_instr,
    output logic         in_ready,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    input  logic [W-1:0] alu_out,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_rd,
    input  logic         res_ready,
    input  logic         host_we,
    input  logic [2:0]   host_waddr,
    input  logic [W-1:0] host_wdata,
    input  logic [2:0]   dbg_raddr,
    output logic [W-1:0] dbg_rdata,
    output logic [15:0]  instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t       state_q;
    logic [W-1:0] instr_q;
    logic [2:0]   opcode_q;
    logic [W-1:0] op1_q;
    logic [W-1:0] op2_q;
    logic [W-1:0] res_q;
    logic         wb_pend_q;
    logic [15:0]  cnt_q;
    logic [W-1:0] rf_q [NREGS];

    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;

    assign rd  = instr_q[8:6];
    assign rs1 = instr_q[5:3];
    assign rs2 = instr_q[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            opcode_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            res_q     <= '0;
            wb_pend_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    // R0 is hardwired to zero, so its storage is never written
                    if (host_we && host_waddr != 3'd0) begin
                        rf_q[host_waddr] <= host_wdata;
                    end
                    if (in_valid) begin
                        instr_q <= in_instr;
                        state_q <= READ;
                    end
                end
                READ: begin
                    op1_q    <= rf_q[rs1];
                    op2_q    <= rf_q[rs2];
                    opcode_q <= instr_q[11:9];
                    state_q  <= EXEC;
                end
                EXEC: begin
                    res_q     <= alu_out;
                    wb_pend_q <= 1'b1;
                    state_q   <= WB;
                end
                WB: begin
                    // Write once even if the consumer stalls us here
                    if (wb_pend_q) begin
                        if (rd != 3'd0) begin
                            rf_q[rd] <= res_q;
                        end
                        wb_pend_q <= 1'b0;
                    end
                    if (res_ready) begin
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign res_valid   = (state_q == WB);
    assign res_data    = res_q;
    assign res_rd      = rd;
    assign alu_opcode  = opcode_q;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign dbg_rdata   = rf_q[dbg_raddr];
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions push expected
// results; a monitor pops and compares on every result handshake.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_instr;
    logic        in_ready;
    logic [2:0]  alu_opcode;
    logic [11:0] alu_op1;
    logic [11:0] alu_op2;
    logic [11:0] alu_out;
    logic        res_valid;
    logic [11:0] res_data;
    logic [2:0]  res_rd;
    logic        res_ready;
    logic        host_we;
    logic [2:0]  host_waddr;
    logic [11:0] host_wdata;
    logic [2:0]  dbg_raddr;
    logic [11:0] dbg_rdata;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .res_ready(res_ready),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .instr_count(instr_count)
    );

    // Reference ALU on the far side of the interface
    always_comb begin
        alu_out = 12'h000;
        case (alu_opcode)
            3'd0: alu_out = alu_op1 + alu_op2;
            3'd1: alu_out = alu_op1 - alu_op2;
            3'd2: alu_out = alu_op1 & alu_op2;
            3'd3: alu_out = alu_op1 | alu_op2;
            3'd4: alu_out = alu_op1 ^ alu_op2;
            3'd5: alu_out = alu_op1 << alu_op2[3:0];
            3'd6: alu_out = alu_op1 >> alu_op2[3:0];
            default: alu_out = alu_op1;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [11:0] exp);
        dbg_raddr = a;
        #1;
        chk($sformatf("dbg_R%0d", a), {4'h0, dbg_rdata}, {4'h0, exp});
    endtask

    task automatic host_write(input logic [2:0] a, input logic [11:0] d);
        host_we = 1'b1;
        host_waddr = a;
        host_wdata = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    // hw: 0 none, 1 host write in accept cycle, 2 host write during READ
    task automatic issue(input logic [11:0] ins, input logic [11:0] ea,
                         input logic [11:0] eb, input logic [11:0] er,
                         input int hw, input logic [2:0] ha,
                         input logic [11:0] hd);
        int k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk("idle_timeout", 16'd0, 16'd1);
        exp_q.push_back({ins[8:6], er});
        in_valid = 1'b1;
        in_instr = ins;
        if (hw == 1) begin
            host_we = 1'b1;
            host_waddr = ha;
            host_wdata = hd;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = ~ins;
        host_we = 1'b0;
        chk("acc_in_ready", {15'd0, in_ready}, 16'd0);
        if (hw == 2) begin
            host_we = 1'b1;
            host_waddr = ha;
            host_wdata = hd;
        end
        @(posedge clk);
        #1;
        host_we = 1'b0;
        chk("exec_opcode", {13'd0, alu_opcode}, {13'd0, ins[11:9]});
        chk("exec_op1", {4'h0, alu_op1}, {4'h0, ea});
        chk("exec_op2", {4'h0, alu_op2}, {4'h0, eb});
        chk("exec_res_valid", {15'd0, res_valid}, 16'd0);
        @(posedge clk);
        #1;
        chk("wb_res_valid", {15'd0, res_valid}, 16'd1);
        if (res_ready) begin
            @(posedge clk);
            #1;
            exp_cnt = exp_cnt + 16'd1;
            chk("post_in_ready", {15'd0, in_ready}, 16'd1);
            chk("instr_count", instr_count, exp_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got rd=%0d data=%h want none",
                         res_rd, res_data);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                chk("sb_result", {1'b0, res_rd, res_data}, {1'b0, e});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        res_ready = 1'b1;
        host_we = 1'b0;
        host_waddr = '0;
        host_wdata = '0;
        dbg_raddr = '0;
        exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_res_data", {4'h0, res_data}, 16'd0);
        chk("rst_res_rd", {13'd0, res_rd}, 16'd0);
        chk("rst_alu", {1'b0, alu_opcode, alu_op1 | alu_op2}, 16'd0);
        chk("rst_count", instr_count, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        host_write(3'd1, 12'h005);
        host_write(3'd2, 12'h003);
        issue({3'd0, 3'd3, 3'd1, 3'd2}, 12'h005, 12'h003, 12'h008, 0, 0, 0);
        chk_reg(3'd3, 12'h008);

        issue({3'd2, 3'd0, 3'd1, 3'd2}, 12'h005, 12'h003, 12'h001, 0, 0, 0);
        chk_reg(3'd0, 12'h000);

        issue({3'd0, 3'd4, 3'd1, 3'd2}, 12'h005, 12'h003, 12'h008, 0, 0, 0);
        issue({3'd1, 3'd5, 3'd4, 3'd2}, 12'h008, 12'h003, 12'h005,
              2, 3'd4, 12'h777);
        chk_reg(3'd4, 12'h008);
        chk_reg(3'd5, 12'h005);

        issue({3'd4, 3'd3, 3'd7, 3'd2}, 12'h0F0, 12'h003, 12'h0F3,
              1, 3'd7, 12'h0F0);
        chk_reg(3'd7, 12'h0F0);
        chk_reg(3'd3, 12'h0F3);

        host_write(3'd6, 12'hFFF);
        issue({3'd0, 3'd5, 3'd6, 3'd1}, 12'hFFF, 12'h005, 12'h004, 0, 0, 0);
        chk_reg(3'd5, 12'h004);

        res_ready = 1'b0;
        issue({3'd3, 3'd6, 3'd1, 3'd4}, 12'h005, 12'h008, 12'h00D, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {15'd0, res_valid}, 16'd1);
            chk("stall_data", {4'h0, res_data}, 16'h00D);
            chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
            chk("stall_count", instr_count, exp_cnt);
        end
        chk_reg(3'd6, 12'h00D);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("stall_release_count", instr_count, exp_cnt);
        chk("stall_release_rdy", {15'd0, in_ready}, 16'd1);

        in_valid = 1'b1;
        in_instr = {3'd0, 3'd7, 3'd1, 3'd2};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("mid_rst_valid", {15'd0, res_valid}, 16'd0);
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        chk("mid_rst_count", instr_count, 16'd0);
        for (int r = 0; r < 8; r++) chk_reg(r[2:0], 12'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", {15'd0, res_valid}, 16'd0);

        host_write(3'd1, 12'h005);
        host_write(3'd2, 12'h003);
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(posedge clk);
        #1;
        exp_cnt = 16'hFFFF;
        issue({3'd0, 3'd3, 3'd1, 3'd2}, 12'h005, 12'h003, 12'h008, 0, 0, 0);

        chk("sb_drained", exp_q.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
